// File: rtl/alu_pipe.sv
// Two-stage pipelined ADD/SUB/AND/XOR ALU with {N,Z,C,V} flags and valid/ready on both sides.
// Define ALU_SATURATE_EN to clamp overflowing ADD/SUB to the signed range instead of wrapping.
module alu_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

`ifdef ALU_SATURATE_EN
  // The overflow direction follows the sign of a for both ADD and SUB.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] r,
                                                input logic ovf,
                                                input logic a_neg);
    logic [WIDTH-1:0] s;
    s = r;
    if (ovf) begin
      s = a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    return s;
  endfunction
`endif

  // Returns {result, N, Z, C, V}; C on SUB is a borrow (a < b unsigned).
  function automatic logic [WIDTH+3:0] alu_eval(input logic [1:0] op,
                                                input logic signed [WIDTH-1:0] x,
                                                input logic signed [WIDTH-1:0] y);
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    ext = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_ADD: begin
        ext = {1'b0, x} + {1'b0, y};
        r   = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        ext = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
        r   = ext[WIDTH-1:0];
        c   = ~ext[WIDTH];
        v   = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      OP_AND: r = x & y;
      OP_XOR: r = x ^ y;
      default: r = '0;
    endcase
`ifdef ALU_SATURATE_EN
    r = saturate(r, v, x[WIDTH-1]);
`endif
    return {r, r[WIDTH-1], (r == '0), c, v};
  endfunction

  logic                    vld_p1_q, vld_p1_d;
  logic [1:0]              mode_p1_q, mode_p1_d;
  logic signed [WIDTH-1:0] a_p1_q, a_p1_d;
  logic signed [WIDTH-1:0] b_p1_q, b_p1_d;
  logic                    vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0]        result_p2_q, result_p2_d;
  logic [3:0]              flags_p2_q, flags_p2_d;
  logic [WIDTH+3:0]        eval_p1;
  logic                    s2_load;
  logic                    s1_adv;
  logic                    s1_load;

  always_comb begin
    s2_load  = !vld_p2_q || out_ready;
    s1_adv   = vld_p1_q && s2_load;
    in_ready = !vld_p1_q || s2_load;
    s1_load  = in_valid && in_ready;
  end

  // Stage p1: operand capture
  always_comb begin
    vld_p1_d  = vld_p1_q;
    mode_p1_d = mode_p1_q;
    a_p1_d    = a_p1_q;
    b_p1_d    = b_p1_q;
    if (in_ready) begin
      vld_p1_d = in_valid;
    end
    if (s1_load) begin
      mode_p1_d = mode;
      a_p1_d    = a;
      b_p1_d    = b;
    end
  end

  // Stage p2: compute and hold result/flags until the consumer takes them
  always_comb begin
    eval_p1     = alu_eval(mode_p1_q, a_p1_q, b_p1_q);
    vld_p2_d    = vld_p2_q;
    result_p2_d = result_p2_q;
    flags_p2_d  = flags_p2_q;
    if (s2_load) begin
      vld_p2_d = vld_p1_q;
    end
    if (s1_adv) begin
      result_p2_d = eval_p1[WIDTH+3:4];
      flags_p2_d  = eval_p1[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      result_p2_q <= '0;
      flags_p2_q  <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      result_p2_q <= result_p2_d;
      flags_p2_q  <= flags_p2_d;
    end
  end

  // Operand registers are qualified by vld_p1_q, so they need no reset.
  always_ff @(posedge clk) begin
    mode_p1_q <= mode_p1_d;
    a_p1_q    <= a_p1_d;
    b_p1_q    <= b_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign result    = result_p2_q;
  assign flags     = flags_p2_q;

endmodule
